// File: rtl/am_bip_tx.sv
// Multi-lane TX alignment-marker inserter with per-lane BIP3/BIP7 parity.
// Sits between the scrambler and the gearbox. Every GAP_N accepted data
// blocks it emits one 66b marker per lane and stalls upstream for that cycle.
module am_bip_tx #(
  parameter int unsigned                LANE_N     = 4,
  parameter int unsigned                HEAD_W     = 2,
  parameter int unsigned                DATA_W     = 64,
  parameter int unsigned                GAP_N      = 16383,
  parameter logic [HEAD_W-1:0]          HEAD_AM    = HEAD_W'(2'b01),
  parameter logic [LANE_N*24-1:0]       MARKER_ENC = (LANE_N*24)'({24'h3d79a2, 24'h9b65c5,
                                                                   24'he6c4f0, 24'h477690})
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       am_en_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [LANE_N*HEAD_W-1:0]   head_i,
  input  logic [LANE_N*DATA_W-1:0]   data_i,
  output logic                       out_valid_o,
  output logic                       marker_v_o,
  output logic [LANE_N*HEAD_W-1:0]   head_o,
  output logic [LANE_N*DATA_W-1:0]   data_o
);

  localparam int unsigned CNT_W = $clog2(GAP_N + 1);
  localparam int unsigned BLK_W = HEAD_W + DATA_W;

  // Interleaved parity: bit k of the block (k>=2) folds into p[(k-2) mod 8];
  // the two header bits fold into p[3] and p[4].
  function automatic logic [7:0] block_bip(input logic [BLK_W-1:0] b);
    logic [7:0] p;
    logic [2:0] idx;
    p = '0;
    for (int k = 2; k < BLK_W; k++) begin
      idx    = 3'((k - 2) % 8);
      p[idx] = p[idx] ^ b[k];
    end
    p[3] = p[3] ^ b[0];
    p[4] = p[4] ^ b[1];
    return p;
  endfunction

  // Marker payload for one lane: M0,M1,M2,BIP3,~M0,~M1,~M2,BIP7 from byte 0 up.
  function automatic logic [63:0] marker_word(input logic [23:0] enc, input logic [7:0] bip3);
    return {~bip3, ~enc[23:16], ~enc[15:8], ~enc[7:0], bip3, enc[23:16], enc[15:8], enc[7:0]};
  endfunction

  logic [CNT_W-1:0]              cnt;
  logic [LANE_N-1:0][7:0]        bip_q;
  logic                          pend;
  logic                          accept;
  logic [LANE_N*HEAD_W-1:0]      marker_head;
  logic [LANE_N*DATA_W-1:0]      marker_data;
  logic [LANE_N-1:0][7:0]        marker_bip;
  logic [LANE_N-1:0][7:0]        data_bip;

  // Marker is owed once GAP_N blocks have gone by in marker mode.
  assign pend       = am_en_i & (cnt == CNT_W'(GAP_N));
  assign in_ready_o = ~pend;
  assign accept     = in_valid_i & ~pend;

  // Per-lane marker image, its own parity, and running parity for a data block.
  always_comb begin
    marker_head = '0;
    marker_data = '0;
    marker_bip  = '0;
    data_bip    = '0;
    for (int l = 0; l < LANE_N; l++) begin
      marker_head[l*HEAD_W +: HEAD_W] = HEAD_AM;
      marker_data[l*DATA_W +: DATA_W] = DATA_W'(marker_word(MARKER_ENC[l*24 +: 24], bip_q[l]));
      marker_bip[l] = block_bip({marker_data[l*DATA_W +: DATA_W], HEAD_AM});
      data_bip[l]   = bip_q[l] ^ block_bip({data_i[l*DATA_W +: DATA_W], head_i[l*HEAD_W +: HEAD_W]});
    end
  end

  // Output register, gap counter and BIP accumulators.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_o <= 1'b0;
      marker_v_o  <= 1'b0;
      head_o      <= '0;
      data_o      <= '0;
      cnt         <= '0;
      bip_q       <= '0;
    end else if (pend) begin
      // Marker goes out regardless of upstream; it opens the next BIP period.
      out_valid_o <= 1'b1;
      marker_v_o  <= 1'b1;
      head_o      <= marker_head;
      data_o      <= marker_data;
      cnt         <= '0;
      bip_q       <= marker_bip;
    end else begin
      marker_v_o <= 1'b0;
      if (accept) begin
        out_valid_o <= 1'b1;
        head_o      <= head_i;
        data_o      <= data_i;
        if (am_en_i) begin
          cnt   <= cnt + CNT_W'(1);
          bip_q <= data_bip;
        end
      end else begin
        out_valid_o <= 1'b0;
      end
      // Pass-through mode keeps the period parked at its start.
      if (!am_en_i) begin
        cnt   <= '0;
        bip_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_am_bip_tx.sv
// Self-checking bench for am_bip_tx: scoreboarded random/directed traffic on a
// GAP_N=4 instance, plus a directed BIP check on a GAP_N=3 instance.
module tb_am_bip_tx;

  localparam int unsigned LN  = 4;
  localparam int unsigned HW  = 2;
  localparam int unsigned DW  = 64;
  localparam int unsigned GAP = 4;
  localparam int unsigned HT  = LN * HW;
  localparam int unsigned DT  = LN * DW;
  localparam logic [95:0] ENC = {24'h3d79a2, 24'h9b65c5, 24'he6c4f0, 24'h477690};

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          am_en = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [HT-1:0] head_i = '0;
  logic [DT-1:0] data_i = '0;
  logic          out_valid;
  logic          marker_v;
  logic [HT-1:0] head_o;
  logic [DT-1:0] data_o;

  logic          b_reset = 1'b1;
  logic          b_en = 1'b0;
  logic          b_valid = 1'b0;
  logic          b_ready;
  logic [HT-1:0] b_head = '0;
  logic [DT-1:0] b_data = '0;
  logic          b_ovalid;
  logic          b_mv;
  logic [HT-1:0] b_head_o;
  logic [DT-1:0] b_data_o;

  always #5 clk = ~clk;

  am_bip_tx #(.LANE_N(LN), .HEAD_W(HW), .DATA_W(DW), .GAP_N(GAP)) dut (
    .clk(clk), .reset(reset), .am_en_i(am_en), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .head_i(head_i), .data_i(data_i), .out_valid_o(out_valid), .marker_v_o(marker_v),
    .head_o(head_o), .data_o(data_o));

  am_bip_tx #(.LANE_N(LN), .HEAD_W(HW), .DATA_W(DW), .GAP_N(3)) dut_b (
    .clk(clk), .reset(b_reset), .am_en_i(b_en), .in_valid_i(b_valid), .in_ready_o(b_ready),
    .head_i(b_head), .data_i(b_data), .out_valid_o(b_ovalid), .marker_v_o(b_mv),
    .head_o(b_head_o), .data_o(b_data_o));

  typedef struct packed {
    logic          valid;
    logic          mark;
    logic [HT-1:0] head;
    logic [DT-1:0] data;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            m_cnt    = 0;
  logic [7:0]    m_bip [LN];
  logic [HT-1:0] m_head   = '0;
  logic [DT-1:0] m_data   = '0;
  logic [HT-1:0] cur_head = '0;
  logic [DT-1:0] cur_data = '0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference parity: p[j] = XOR b[j+2+8m], plus header bits into p[3]/p[4].
  function automatic logic [7:0] ref_bip(input logic [65:0] b);
    logic [7:0] p = '0;
    for (int j = 0; j < 8; j++)
      for (int k = j + 2; k <= 65; k += 8)
        p[j] ^= b[k];
    p[3] ^= b[0];
    p[4] ^= b[1];
    return p;
  endfunction

  function automatic logic [63:0] ref_marker(input int l, input logic [7:0] bip);
    logic [95:0] enc = ENC;
    logic [7:0]  m0 = enc[l*24 +: 8];
    logic [7:0]  m1 = enc[l*24+8 +: 8];
    logic [7:0]  m2 = enc[l*24+16 +: 8];
    return {~bip, ~m2, ~m1, ~m0, bip, m2, m1, m0};
  endfunction

  task automatic new_block();
    cur_head = HT'($urandom);
    for (int w = 0; w < DT / 32; w++) cur_data[w*32 +: 32] = $urandom;
  endtask

  // One cycle on the main DUT: predict, push, clock, pop and compare.
  task automatic step(input logic v, input logic en, input logic rst);
    exp_t e;
    exp_t g;
    logic pend;
    logic acc = 1'b0;
    am_en = en; in_valid = v; reset = rst;
    head_i = cur_head; data_i = cur_data;
    pend = en && (m_cnt == GAP);
    check_eq("in_ready", in_ready, !pend);
    e = '0;
    if (rst) begin
      m_cnt = 0; m_head = '0; m_data = '0;
      for (int l = 0; l < LN; l++) m_bip[l] = '0;
    end else if (pend) begin
      e.valid = 1'b1; e.mark = 1'b1;
      for (int l = 0; l < LN; l++) begin
        e.head[l*HW +: HW] = 2'b01;
        e.data[l*DW +: DW] = ref_marker(l, m_bip[l]);
        m_bip[l] = ref_bip({e.data[l*DW +: DW], 2'b01});
      end
      m_cnt = 0; m_head = e.head; m_data = e.data;
    end else begin
      if (v) begin
        acc = 1'b1;
        e.valid = 1'b1; e.head = cur_head; e.data = cur_data;
        m_head = cur_head; m_data = cur_data;
        if (en) begin
          m_cnt++;
          for (int l = 0; l < LN; l++)
            m_bip[l] ^= ref_bip({cur_data[l*DW +: DW], cur_head[l*HW +: HW]});
        end
      end else begin
        e.head = m_head; e.data = m_data;
      end
      if (!en) begin
        m_cnt = 0;
        for (int l = 0; l < LN; l++) m_bip[l] = '0;
      end
    end
    sb.push_back(e);
    @(posedge clk); #1;
    g = sb.pop_front();
    check_eq("out_valid", out_valid, g.valid);
    check_eq("marker_v", marker_v, g.mark);
    check_eq("head_o", head_o, g.head);
    check_eq("data_o", data_o, g.data);
    if (g.mark) begin
      check_eq("am_lane0_enc", data_o[23:0], 24'h477690);
      check_eq("am_lane0_head", head_o[1:0], 2'b01);
    end
    if (acc) new_block();
  endtask

  initial begin
    int guard;
    for (int l = 0; l < LN; l++) m_bip[l] = '0;
    new_block();

    // Reset held with valid asserted.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_data", data_o, '0);

    // Continuous traffic: D1..D4, marker, D5.. with no loss.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0);

    // Bubble at cnt==2, and valid dropped while a marker is owed.
    guard = 0;
    while (m_cnt != 2 && guard < 20) begin step(1'b1, 1'b1, 1'b0); guard++; end
    check_eq("reach_cnt2", m_cnt, 2);
    step(1'b0, 1'b1, 1'b0);
    guard = 0;
    while (m_cnt != GAP && guard < 20) begin step(1'b1, 1'b1, 1'b0); guard++; end
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);

    // Pass-through mode, then reassert.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0);

    // Mid-period reset at cnt==2 with accumulated parity.
    guard = 0;
    while (m_cnt != 2 && guard < 20) begin step(1'b1, 1'b1, 1'b0); guard++; end
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);

    // Random valid with occasional mode drops.
    for (int i = 0; i < 80; i++)
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) != 0), 1'b0);

    // Directed BIP check on the GAP_N=3 instance.
    @(posedge clk); #1;
    b_reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    b_reset = 1'b0; b_en = 1'b1; b_valid = 1'b1; b_head = 8'h55; b_data = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("b_data_valid", b_ovalid, 1'b1);
      check_eq("b_data_mark", b_mv, 1'b0);
    end
    check_eq("b_ready_stall", b_ready, 1'b0);
    @(posedge clk); #1;
    b_valid = 1'b0;
    check_eq("b_am_valid", b_mv, 1'b1);
    check_eq("b_am_head", b_head_o, 8'h55);
    for (int l = 0; l < LN; l++)
      check_eq($sformatf("b_am_lane%0d", l), b_data_o[l*DW +: DW], ref_marker(l, 8'h08));
    check_eq("b_am_lane1_word", b_data_o[DW +: DW], 64'hF719_3B0F_08E6_C4F0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
